// File: rtl/icache_responder_pkg.sv
// Shared cache geometry defaults, FSM state type and address-field helpers
// used by the instruction cache responder and its storage array.
package icache_responder_pkg;

  localparam int unsigned ICACHE_INDEX_BITS  = 6;
  localparam int unsigned ICACHE_OFFSET_BITS = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RESP
  } state_t;

  // Field extractors return right-aligned values; callers size-cast to the field width.
  function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int unsigned ob);
    return (addr >> 2) & ((32'd1 << ob) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int unsigned ib,
                                             input int unsigned ob);
    return (addr >> (ob + 2)) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned ib,
                                           input int unsigned ob);
    return addr >> (ib + ob + 2);
  endfunction

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned ob);
    return addr & ~((32'd1 << (ob + 2)) - 32'd1);
  endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetcher request/reply and memory-arbiter read channel of the instruction cache.
// slave = cache side, master = fetcher/arbiter side.
interface icache_responder_if;
  logic        fetch_able;
  logic [31:0] fetch_pc;
  logic        flush;
  logic [31:0] ins_out;
  logic        ins_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_done;

  modport slave (
    input  fetch_able, fetch_pc, flush, mem_rdata, mem_done,
    output ins_out, ins_ready, mem_req, mem_addr
  );

  modport master (
    output fetch_able, fetch_pc, flush, mem_rdata, mem_done,
    input  ins_out, ins_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder_array.sv
// Valid/tag/data storage of the direct-mapped cache: asynchronous read by index,
// synchronous whole-line write, valid bits cleared by the asynchronous reset.
module icache_array #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 2,
  parameter int unsigned TAG_BITS    = 22
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [INDEX_BITS-1:0]             rd_index,
  output logic                              rd_valid,
  output logic [TAG_BITS-1:0]               rd_tag,
  output logic [(32<<OFFSET_BITS)-1:0]      rd_line,
  input  logic                              wr_en,
  input  logic [INDEX_BITS-1:0]             wr_index,
  input  logic [TAG_BITS-1:0]               wr_tag,
  input  logic [(32<<OFFSET_BITS)-1:0]      wr_line
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]              valid_q;
  logic [TAG_BITS-1:0]           tag_mem  [LINES];
  logic [(32<<OFFSET_BITS)-1:0]  data_mem [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache responder: one-cycle hit replies, whole-line
// miss fills from the memory arbiter. Define ICACHE_PERF_EN for hit/miss counters.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = ICACHE_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = ICACHE_OFFSET_BITS
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  icache_responder_if.slave bus
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned WORDS    = 1 << OFFSET_BITS;
  localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS - 2;

  typedef logic [WORDS-1:0][31:0] line_t;

  state_t                 state_q, state_n;
  logic [31:0]            req_pc_q, req_pc_n;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_n;
  logic                   drop_q, drop_n;
  line_t                  buf_q, buf_n;
  logic [31:0]            ins_out_q, ins_out_n;
  logic                   ins_ready_q, ins_ready_n;
  logic                   mem_req_q, mem_req_n;
  logic [31:0]            mem_addr_q, mem_addr_n;

  logic [INDEX_BITS-1:0]  fetch_index, req_index;
  logic [TAG_BITS-1:0]    fetch_tag, req_tag;
  logic [OFFSET_BITS-1:0] fetch_off, req_off;
  logic                   rd_valid;
  logic [TAG_BITS-1:0]    rd_tag;
  line_t                  rd_line;
  line_t                  fill_line;
  logic                   hit;
  logic                   wr_en;

  assign fetch_index = INDEX_BITS'(addr_index(bus.fetch_pc, INDEX_BITS, OFFSET_BITS));
  assign fetch_tag   = TAG_BITS'(addr_tag(bus.fetch_pc, INDEX_BITS, OFFSET_BITS));
  assign fetch_off   = OFFSET_BITS'(addr_offset(bus.fetch_pc, OFFSET_BITS));
  assign req_index   = INDEX_BITS'(addr_index(req_pc_q, INDEX_BITS, OFFSET_BITS));
  assign req_tag     = TAG_BITS'(addr_tag(req_pc_q, INDEX_BITS, OFFSET_BITS));
  assign req_off     = OFFSET_BITS'(addr_offset(req_pc_q, OFFSET_BITS));

  assign hit = rd_valid && (rd_tag == fetch_tag);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .OFFSET_BITS(OFFSET_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk     (clk_in),
    .rst_n   (rst_in),
    .rd_index(fetch_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_line (rd_line),
    .wr_en   (wr_en && rdy_in),
    .wr_index(req_index),
    .wr_tag  (req_tag),
    .wr_line (fill_line)
  );

  always_comb begin
    state_n     = state_q;
    req_pc_n    = req_pc_q;
    cnt_n       = cnt_q;
    drop_n      = drop_q;
    buf_n       = buf_q;
    ins_out_n   = ins_out_q;
    ins_ready_n = 1'b0;
    mem_req_n   = mem_req_q;
    mem_addr_n  = mem_addr_q;
    wr_en       = 1'b0;
    // Line as it stands once the word arriving this cycle lands; written to the
    // array on the last word so the reply can come from the same value.
    fill_line          = buf_q;
    fill_line[cnt_q]   = bus.mem_rdata;

    case (state_q)
      ST_IDLE: begin
        if (!bus.flush && bus.fetch_able) begin
          if (hit) begin
            ins_out_n   = rd_line[fetch_off];
            ins_ready_n = 1'b1;
            state_n     = ST_RESP;
          end else begin
            req_pc_n   = bus.fetch_pc;
            cnt_n      = '0;
            drop_n     = 1'b0;
            mem_req_n  = 1'b1;
            mem_addr_n = line_base(bus.fetch_pc, OFFSET_BITS);
            state_n    = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        drop_n = drop_q | bus.flush;
        if (bus.mem_done) begin
          buf_n = fill_line;
          cnt_n = OFFSET_BITS'(cnt_q + 1'b1);
          if (cnt_q == '1) begin
            wr_en     = 1'b1;
            mem_req_n = 1'b0;
            if (drop_q || bus.flush) begin
              state_n = ST_IDLE;
            end else begin
              ins_out_n   = fill_line[req_off];
              ins_ready_n = 1'b1;
              state_n     = ST_RESP;
            end
          end else begin
            mem_addr_n = mem_addr_q + 32'd4;
          end
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      req_pc_q    <= '0;
      cnt_q       <= '0;
      drop_q      <= 1'b0;
      buf_q       <= '0;
      ins_out_q   <= '0;
      ins_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy_in) begin
      state_q     <= state_n;
      req_pc_q    <= req_pc_n;
      cnt_q       <= cnt_n;
      drop_q      <= drop_n;
      buf_q       <= buf_n;
      ins_out_q   <= ins_out_n;
      ins_ready_q <= ins_ready_n;
      mem_req_q   <= mem_req_n;
      mem_addr_q  <= mem_addr_n;
    end
  end

  assign bus.ins_out   = ins_out_q;
  assign bus.ins_ready = ins_ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;

`ifdef ICACHE_PERF_EN
  logic lookup;
  assign lookup = (state_q == ST_IDLE) && !bus.flush && bus.fetch_able;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy_in && lookup) begin
      if (hit) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder with a line-level cache model and a per-cycle compare process.
module tb_icache_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;

  icache_responder_if bus ();

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_responder dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .rdy_in(rdy),
    .bus   (bus)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt (hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: per-index valid/tag; line contents always equal the memory image.
  bit          m_valid [64];
  logic [21:0] m_tag   [64];
  int          m_hits = 0;
  int          m_misses = 0;

  logic        exp_ready = 1'b0;
  logic [31:0] exp_out = '0;
  logic        exp_mem_req = 1'b0;
  logic [31:0] exp_addr = '0;
  bit          chk_en = 1'b0;
  logic        prev_ready = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a & 32'hFFFF_FFFC)
      32'h10:  return 32'h11;
      32'h14:  return 32'h22;
      32'h18:  return 32'h33;
      32'h1C:  return 32'h44;
      default: return (a & 32'hFFFF_FFFC) ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) & 32'd63);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == a[31:10]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ins_ready", 32'(bus.ins_ready), 32'(exp_ready));
      if (exp_ready) check("ins_out", bus.ins_out, exp_out);
      check("mem_req", 32'(bus.mem_req), 32'(exp_mem_req));
      if (exp_mem_req) check("mem_addr", bus.mem_addr, exp_addr);
      check("ready_back_to_back", 32'(prev_ready & bus.ins_ready), 32'd0);
      prev_ready = bus.ins_ready;
    end
  end

  // One fetch. flush_after: flush pulse in the cycle after word k's mem_done;
  // flush_with: flush together with word k's mem_done; stall_after: rdy low 5 cycles after word k.
  task automatic fetch(input logic [31:0] pc, input int gap, input int flush_after,
                       input int flush_with, input int stall_after);
    logic [31:0] base;
    bit drop;
    base = pc & 32'hFFFF_FFF0;
    drop = 1'b0;
    bus.fetch_able = 1'b1;
    bus.fetch_pc   = pc;
    if (model_hit(pc)) begin
      m_hits++;
      step();
      exp_ready = 1'b1;
      exp_out   = mem_word(pc);
      bus.fetch_able = 1'b0;
      step();
      exp_ready = 1'b0;
      return;
    end
    m_misses++;
    step();
    exp_mem_req = 1'b1;
    exp_addr    = base;
    for (int w = 0; w < 4; w++) begin
      repeat (gap) step();
      bus.mem_done  = 1'b1;
      bus.mem_rdata = mem_word(base + 32'(4 * w));
      if (w == flush_with) begin
        bus.flush = 1'b1;
        bus.fetch_able = 1'b0;
        drop = 1'b1;
      end
      step();
      bus.mem_done = 1'b0;
      bus.flush    = 1'b0;
      if (w < 3) begin
        exp_addr = base + 32'(4 * (w + 1));
      end else begin
        exp_mem_req = 1'b0;
        m_valid[idx_of(pc)] = 1'b1;
        m_tag[idx_of(pc)]   = pc[31:10];
        if (!drop) begin
          exp_ready = 1'b1;
          exp_out   = mem_word(pc);
        end
      end
      if (w == flush_after) begin
        bus.flush = 1'b1;
        bus.fetch_able = 1'b0;
        drop = 1'b1;
        step();
        bus.flush = 1'b0;
      end
      if (w == stall_after) begin
        rdy = 1'b0;
        repeat (5) step();
        rdy = 1'b1;
      end
    end
    bus.fetch_able = 1'b0;
    if (!drop) begin
      step();
      exp_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.fetch_able = 1'b0;
    bus.fetch_pc   = '0;
    bus.flush      = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_done   = 1'b0;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;

    #12;
    check("rst_ins_ready", 32'(bus.ins_ready), 32'd0);
    check("rst_ins_out", bus.ins_out, 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    chk_en = 1'b1;

    // Cold miss, back-to-back mem_done
    fetch(32'h10, 0, -1, -1, -1);
    check("cold_data", bus.ins_out, 32'h11);
    check("cold_last_addr", bus.mem_addr, 32'h1C);
    step();

    // Hit after fill
    fetch(32'h18, 0, -1, -1, -1);
    check("hit_data", bus.ins_out, 32'h33);

    // Conflict on index 1
    fetch(32'h410, 1, -1, -1, -1);
    check("conflict_data", bus.ins_out, 32'h5A5A_0410);
    fetch(32'h10, 1, -1, -1, -1);
    check("refill_data", bus.ins_out, 32'h11);

    // Flush after the 2nd mem_done: no reply, line still installed
    fetch(32'h20, 1, 1, -1, -1);
    step();
    fetch(32'h24, 0, -1, -1, -1);
    check("flush_fill_hit", bus.ins_out, 32'h5A5A_0024);

    // Flush together with the last mem_done
    fetch(32'h30, 1, -1, 3, -1);
    step();
    fetch(32'h3C, 0, -1, -1, -1);
    check("flush_last_hit", bus.ins_out, 32'h5A5A_003C);

    // rdy_in low for 5 cycles mid-fill
    fetch(32'h44, 1, -1, -1, 0);
    check("stall_data", bus.ins_out, 32'h5A5A_0044);

    // Stale hold: fetch_able kept high across the RESP gap
    bus.fetch_able = 1'b1;
    bus.fetch_pc   = 32'h14;
    step();
    m_hits++;
    exp_ready = 1'b1;
    exp_out   = mem_word(32'h14);
    step();
    exp_ready = 1'b0;
    step();
    m_hits++;
    exp_ready = 1'b1;
    bus.fetch_able = 1'b0;
    step();
    exp_ready = 1'b0;
    check("stale_data", bus.ins_out, 32'h22);

    // Flush in IDLE: the request that cycle is not sampled
    bus.fetch_able = 1'b1;
    bus.fetch_pc   = 32'h80;
    bus.flush      = 1'b1;
    step();
    bus.flush      = 1'b0;
    bus.fetch_able = 1'b0;
    step();

    // Reset mid-fill: mem_req drops at once, line not installed, all valids cleared
    bus.fetch_able = 1'b1;
    bus.fetch_pc   = 32'h50;
    step();
    exp_mem_req = 1'b1;
    exp_addr    = 32'h50;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = mem_word(32'h50);
    step();
    bus.mem_done = 1'b0;
    bus.fetch_able = 1'b0;
    exp_addr = 32'h54;
    #2 rst_n = 1'b0;
    exp_mem_req = 1'b0;
    #1;
    check("rst_mid_fill_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_fill_addr", bus.mem_addr, 32'd0);
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    fetch(32'h50, 1, -1, -1, -1);
    check("post_rst_data", bus.ins_out, 32'h5A5A_0050);
    fetch(32'h1C, 0, -1, -1, -1);
    check("post_rst_refill", bus.ins_out, 32'h44);
    fetch(32'h14, 0, -1, -1, -1);
    check("post_rst_hit", bus.ins_out, 32'h22);
    step();

`ifdef ICACHE_PERF_EN
    check("hit_cnt", hit_cnt, 32'(m_hits));
    check("miss_cnt", miss_cnt, 32'(m_misses));
`endif

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
